// File: rtl/code_mem_pkg.sv
// Shared types and defaults for the code-memory fetch bridge.
package code_mem_pkg;

  localparam int unsigned CODE_MEM_ADDR_WIDTH    = 32;
  localparam int unsigned CODE_MEM_DATA_WIDTH    = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } bridge_state_e;

  // Width of the WAIT-state watchdog counter; counts 0 .. cycles-1.
  function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
    return (cycles > 2) ? int'($clog2(cycles)) : 1;
  endfunction

endpackage

// File: rtl/code_fetch_buf.sv
// Single-entry instruction buffer: tag/data/valid with lookup, fill and flush.
module code_fetch_buf
  import code_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = CODE_MEM_ADDR_WIDTH,
  parameter int unsigned DATA_W = CODE_MEM_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit_c,
  output logic [DATA_W-1:0] rd_data,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              flush
);

  logic              valid;
  logic [ADDR_W-1:0] tag;

  // Entry update; a flush in the same cycle as a fill leaves the entry invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      tag     <= '0;
      rd_data <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid   <= 1'b1;
      tag     <= fill_addr;
      rd_data <= fill_data;
    end
  end

  assign hit_c = valid && (tag == lookup_addr);

endmodule

// File: rtl/code_mem_bridge.sv
// Bridges core instruction fetches onto a req/gnt/rvalid memory port,
// with a one-entry fetch buffer and a WAIT-state watchdog.
module code_mem_bridge
  import code_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = CODE_MEM_ADDR_WIDTH,
  parameter int unsigned DATA_W         = CODE_MEM_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              code_mem_available_o,
  input  logic              code_read_valid_i,
  input  logic [ADDR_W-1:0] code_read_addr_i,
  output logic              code_read_ready_o,
  output logic [DATA_W-1:0] code_read_data_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              timeout_err_o
);

  localparam int unsigned CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e     state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;
  logic              stale;

  logic              buf_hit_c;
  logic [DATA_W-1:0] buf_data;
  logic              lookup_hit_c;
  logic              rsp_fill_c;
  logic              timeout_c;

  // Buffer hit only counts in IDLE with a live request and no flush this cycle.
  assign lookup_hit_c = (state == ST_IDLE) && code_read_valid_i && buf_hit_c && !flush_i;
  // A real response: rvalid in WAIT that is not the late beat of an aborted fetch.
  assign rsp_fill_c   = (state == ST_WAIT) && mem_rvalid_i && !stale;
  // Watchdog expiry; a simultaneous real response takes precedence.
  assign timeout_c    = (state == ST_WAIT) && (cnt == CNT_LAST) && !rsp_fill_c;

  code_fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_addr (code_read_addr_i),
    .hit_c       (buf_hit_c),
    .rd_data     (buf_data),
    .fill        (rsp_fill_c),
    .fill_addr   (addr_q),
    .fill_data   (mem_rdata_i),
    .flush       (flush_i)
  );

  // Fetch FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      addr_q               <= '0;
      cnt                  <= '0;
      stale                <= 1'b0;
      code_mem_available_o <= 1'b1;
      code_read_ready_o    <= 1'b0;
      code_read_data_o     <= '0;
      mem_req_o            <= 1'b0;
      mem_addr_o           <= '0;
      timeout_err_o        <= 1'b0;
    end else begin
      code_read_ready_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (code_read_valid_i) begin
            addr_q               <= code_read_addr_i;
            code_mem_available_o <= 1'b0;
            if (lookup_hit_c) begin
              code_read_data_o  <= buf_data;
              code_read_ready_o <= 1'b1;
              state             <= ST_RSP;
            end else begin
              mem_req_o  <= 1'b1;
              mem_addr_o <= code_read_addr_i;
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            cnt       <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (rsp_fill_c) begin
            code_read_data_o  <= mem_rdata_i;
            code_read_ready_o <= 1'b1;
            state             <= ST_RSP;
          end else if (timeout_c) begin
            code_read_data_o  <= '0;
            code_read_ready_o <= 1'b1;
            timeout_err_o     <= 1'b1;
            stale             <= 1'b1;
            state             <= ST_RSP;
          end else if (mem_rvalid_i) begin
            stale <= 1'b0;
          end
        end
        ST_RSP: begin
          code_mem_available_o <= 1'b1;
          state                <= ST_IDLE;
        end
        default: begin
          code_mem_available_o <= 1'b1;
          state                <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_mem_bridge.sv
// Scoreboard bench for code_mem_bridge with a directed memory-side driver.
module tb_code_mem_bridge;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              code_mem_available_o;
  logic              code_read_valid_i = 1'b0;
  logic [ADDR_W-1:0] code_read_addr_i = '0;
  logic              code_read_ready_o;
  logic [DATA_W-1:0] code_read_data_o;
  logic              flush_i = 1'b0;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              timeout_err_o;

  code_mem_bridge #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .code_mem_available_o (code_mem_available_o),
    .code_read_valid_i    (code_read_valid_i),
    .code_read_addr_i     (code_read_addr_i),
    .code_read_ready_o    (code_read_ready_o),
    .code_read_data_o     (code_read_data_o),
    .flush_i              (flush_i),
    .mem_req_o            (mem_req_o),
    .mem_addr_o           (mem_addr_o),
    .mem_gnt_i            (mem_gnt_i),
    .mem_rvalid_i         (mem_rvalid_i),
    .mem_rdata_i          (mem_rdata_i),
    .timeout_err_o        (timeout_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                at;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && code_read_ready_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got data 0x%0h at cycle %0d, required no response",
                 code_read_data_o, cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_data", 64'(code_read_data_o), 64'(e.data));
        check("rsp_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_until(input int at);
    int n;
    n = 0;
    while (cyc < at && n < 200) begin
      tick();
      n++;
    end
    if (cyc != at) check("schedule", 64'(cyc), 64'(at));
  endtask

  // Present one fetch; for an expected hit the response is queued for the next cycle.
  task automatic issue(input logic [ADDR_W-1:0] a, input logic hit,
                       input logic [DATA_W-1:0] d, output int acc);
    int n;
    n = 0;
    while (code_mem_available_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (code_mem_available_o !== 1'b1) check("avail_wait", 64'(code_mem_available_o), 64'(1));
    code_read_valid_i = 1'b1;
    code_read_addr_i  = a;
    acc = cyc;
    if (hit) sb.push_back('{d, cyc + 1});
    tick();
    code_read_valid_i = 1'b0;
    check(hit ? "hit_no_req" : "miss_req", 64'(mem_req_o), 64'(!hit));
  endtask

  // Wait for the request, optionally stall the grant, then grant it.
  task automatic grant(input logic [ADDR_W-1:0] a, input int stall, output int g);
    int n;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 64'(mem_req_o), 64'(1));
    check("req_addr", 64'(mem_addr_o), 64'(a));
    for (int i = 0; i < stall; i++) begin
      check("stall_req", 64'(mem_req_o), 64'(1));
      check("stall_addr", 64'(mem_addr_o), 64'(a));
      check("stall_avail", 64'(code_mem_available_o), 64'(0));
      tick();
    end
    mem_gnt_i = 1'b1;
    g = cyc;
    tick();
    mem_gnt_i = 1'b0;
  endtask

  task automatic rvalid_at(input int at, input logic [DATA_W-1:0] d,
                           input logic push, input logic fl);
    wait_until(at);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = d;
    flush_i      = fl;
    if (push) sb.push_back('{d, cyc + 1});
    tick();
    mem_rvalid_i = 1'b0;
    flush_i      = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acc;
    int g;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_avail", 64'(code_mem_available_o), 64'(1));
    check("rst_ready", 64'(code_read_ready_o), 64'(0));
    check("rst_data", 64'(code_read_data_o), 64'(0));
    check("rst_req", 64'(mem_req_o), 64'(0));
    check("rst_addr", 64'(mem_addr_o), 64'(0));
    check("rst_err", 64'(timeout_err_o), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Miss then hit on 0x0010.
    issue(16'h0010, 1'b0, '0, acc);
    grant(16'h0010, 0, g);
    rvalid_at(g + 3, 32'hDEADBEEF, 1'b1, 1'b0);
    tick();
    issue(16'h0010, 1'b1, 32'hDEADBEEF, acc);
    tick();
    check("hit_no_req_later", 64'(mem_req_o), 64'(0));

    // Grant stall for 5 cycles.
    issue(16'h0060, 1'b0, '0, acc);
    grant(16'h0060, 5, g);
    rvalid_at(g + 1, 32'h60606060, 1'b1, 1'b0);
    tick();

    // Flush after fill forces a miss.
    issue(16'h0020, 1'b0, '0, acc);
    grant(16'h0020, 0, g);
    rvalid_at(g + 2, 32'h20202020, 1'b1, 1'b0);
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    issue(16'h0020, 1'b0, '0, acc);
    grant(16'h0020, 0, g);
    rvalid_at(g + 1, 32'h20202021, 1'b1, 1'b0);

    // Flush coincident with fill: next fetch of the same address misses.
    issue(16'h0030, 1'b0, '0, acc);
    grant(16'h0030, 0, g);
    rvalid_at(g + 2, 32'h30303030, 1'b1, 1'b1);
    issue(16'h0030, 1'b0, '0, acc);
    grant(16'h0030, 0, g);
    rvalid_at(g + 1, 32'h30303031, 1'b1, 1'b0);

    // rvalid on the last WAIT cycle wins over the watchdog.
    issue(16'h0070, 1'b0, '0, acc);
    grant(16'h0070, 0, g);
    rvalid_at(g + TMO, 32'h70707070, 1'b1, 1'b0);
    tick();
    tick();
    check("boundary_no_err", 64'(timeout_err_o), 64'(0));

    // Timeout: zero data 8 cycles after entering WAIT, sticky error.
    issue(16'h0080, 1'b0, '0, acc);
    grant(16'h0080, 0, g);
    sb.push_back('{32'h0, g + TMO + 1});
    wait_until(g + TMO);
    check("err_before_expiry", 64'(timeout_err_o), 64'(0));
    wait_until(g + TMO + 2);
    check("err_after_expiry", 64'(timeout_err_o), 64'(1));

    // Buffer left untouched by the timeout.
    issue(16'h0070, 1'b1, 32'h70707070, acc);
    tick();

    // Late beat from the aborted fetch is dropped.
    issue(16'h0040, 1'b0, '0, acc);
    grant(16'h0040, 0, g);
    rvalid_at(g + 2, 32'h00001111, 1'b0, 1'b0);
    rvalid_at(g + 4, 32'h00002222, 1'b1, 1'b0);
    tick();
    check("err_sticky", 64'(timeout_err_o), 64'(1));

    // Reset in the middle of WAIT.
    issue(16'h0050, 1'b0, '0, acc);
    grant(16'h0050, 0, g);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_avail", 64'(code_mem_available_o), 64'(1));
    check("midrst_ready", 64'(code_read_ready_o), 64'(0));
    check("midrst_data", 64'(code_read_data_o), 64'(0));
    check("midrst_req", 64'(mem_req_o), 64'(0));
    check("midrst_addr", 64'(mem_addr_o), 64'(0));
    check("midrst_err", 64'(timeout_err_o), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    issue(16'h0040, 1'b0, '0, acc);
    grant(16'h0040, 0, g);
    rvalid_at(g + 1, 32'h00004444, 1'b1, 1'b0);
    repeat (4) tick();

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
